// File: rtl/rle_pkg.sv
// Shared RLE format definitions: FSM states, entry field layout, entry unpack helper.
// Both the compressor and the decoder import this so the on-SRAM format stays in lockstep.
package rle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_EXPAND,
    S_WRITE,
    S_FLUSH,
    S_DONE
  } rle_state_e;

  // One entry is {byte, count}; two entries per 32-bit word, low half first.
  localparam int BYTE_MSB = 15;
  localparam int BYTE_LSB = 8;
  localparam int CNT_MSB  = 7;
  localparam int CNT_LSB  = 0;
  localparam int ENTRY_W  = 16;

  typedef struct packed {
    logic [BYTE_MSB-BYTE_LSB:0] sym;
    logic [CNT_MSB-CNT_LSB:0]   cnt;
  } rle_entry_t;

  function automatic rle_entry_t unpack_entry(input logic [ENTRY_W-1:0] e);
    rle_entry_t r;
    r.sym = e[BYTE_MSB:BYTE_LSB];
    r.cnt = e[CNT_MSB:CNT_LSB];
    return r;
  endfunction

endpackage

// File: rtl/rle_decode_byte_packer.sv
// Little-endian byte accumulator: first pushed byte lands in [7:0].
// full_o flags the push that completes the word so the caller can write it next cycle.
module rle_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [31:0] word_o
);

  logic [2:0]  cnt_q;
  logic [31:0] word_q;

  // Clear wins over push; cleared bytes stay zero so a partial word is zero-padded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (push_i) begin
      for (int b = 0; b < 4; b++) begin
        if (cnt_q[1:0] == 2'(b)) word_q[8*b +: 8] <= byte_i;
      end
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign full_o  = push_i && (cnt_q == 3'd3);
  assign empty_o = (cnt_q == 3'd0);
  assign word_o  = word_q;

endmodule

// File: rtl/rle_decode.sv
// RLE decoder: reads {byte,count} entries from DPSRAM port A, expands them and
// writes the packed plaintext back through the same port. Single port, so a
// write cycle stalls expansion and reads only happen between runs.
module rle_decode
  import rle_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [31:0]       rle_size,
  input  logic [31:0]       message_addr,
  output logic [31:0]       message_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic              port_A_we
);

  rle_state_e           state_q;
  logic [ADDR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [ENTRY_W-1:0]   hi_q;        // upper entry of the current word, consumed second
  logic                 half_q;      // 1 once the upper entry is in use
  logic [COUNT_W-1:0]   run_q;
  logic [7:0]           sym_q;
  logic [31:0]          ent_left_q;  // entries still to finish, including the current one
  logic [31:0]          msg_size_q;
  logic                 done_q;

  logic        pk_push, pk_clear, pk_full, pk_empty;
  logic [31:0] pk_word;
  logic [31:0] n_entries;
  logic        run_last, last_entry;
  rle_entry_t  lo_ent, hi_ent;

  assign port_A_clk   = clk;
  assign message_size = msg_size_q;
  assign done         = done_q;

  assign n_entries  = {1'b0, rle_size[31:1]};
  assign lo_ent     = unpack_entry(port_A_data_out[ENTRY_W-1:0]);
  assign hi_ent     = unpack_entry(hi_q);
  assign run_last   = (run_q == '0) || (run_q == COUNT_W'(1));
  assign last_entry = (ent_left_q == 32'd1);

  assign pk_push  = (state_q == S_EXPAND) && (run_q != '0);
  assign pk_clear = ((state_q == S_IDLE) && start) || (state_q == S_WRITE) || (state_q == S_FLUSH);

  // Address bits above ADDR_W are dropped by design; bit 0 of rle_size is ignored.
  logic unused_bits;
  assign unused_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W], rle_size[0]};

  rle_byte_packer u_packer (
    .clk     (clk),
    .rst     (reset),
    .clear_i (pk_clear),
    .push_i  (pk_push),
    .byte_i  (sym_q),
    .full_o  (pk_full),
    .empty_o (pk_empty),
    .word_o  (pk_word)
  );

  // Port A is a pure decode of registered state: zero whenever not reading or writing.
  always_comb begin
    port_A_we      = 1'b0;
    port_A_addr    = '0;
    port_A_data_in = '0;
    case (state_q)
      S_RD_REQ: port_A_addr = rd_ptr_q;
      S_WRITE, S_FLUSH: begin
        port_A_we      = 1'b1;
        port_A_addr    = wr_ptr_q;
        port_A_data_in = pk_word;
      end
      default: ;
    endcase
  end

  // Decoder FSM with its pointers, run counter and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      hi_q       <= '0;
      half_q     <= 1'b0;
      run_q      <= '0;
      sym_q      <= '0;
      ent_left_q <= '0;
      msg_size_q <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_ptr_q   <= rle_addr[ADDR_W-1:0];
            wr_ptr_q   <= message_addr[ADDR_W-1:0];
            ent_left_q <= n_entries;
            run_q      <= '0;
            half_q     <= 1'b0;
            done_q     <= 1'b0;
            msg_size_q <= '0;
            state_q    <= (n_entries == '0) ? S_DONE : S_RD_REQ;
          end
        end
        S_RD_REQ: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          hi_q     <= port_A_data_out[2*ENTRY_W-1:ENTRY_W];
          run_q    <= COUNT_W'(lo_ent.cnt);
          sym_q    <= lo_ent.sym;
          half_q   <= 1'b0;
          rd_ptr_q <= rd_ptr_q + ADDR_W'(4);
          state_q  <= S_EXPAND;
        end
        S_EXPAND: begin
          if (pk_push) begin
            msg_size_q <= msg_size_q + 32'd1;
            run_q      <= run_q - COUNT_W'(1);
          end
          if (pk_full) begin
            // Entry bookkeeping is deferred to WRITE so the stall is one clean cycle.
            state_q <= S_WRITE;
          end else if (run_last) begin
            ent_left_q <= ent_left_q - 32'd1;
            if (last_entry)
              state_q <= (pk_push || !pk_empty) ? S_FLUSH : S_DONE;
            else if (!half_q) begin
              half_q <= 1'b1;
              run_q  <= COUNT_W'(hi_ent.cnt);
              sym_q  <= hi_ent.sym;
            end else
              state_q <= S_RD_REQ;
          end
        end
        S_WRITE: begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(4);
          if (run_q != '0) begin
            state_q <= S_EXPAND;
          end else begin
            ent_left_q <= ent_left_q - 32'd1;
            if (last_entry)
              state_q <= S_DONE;
            else if (!half_q) begin
              half_q  <= 1'b1;
              run_q   <= COUNT_W'(hi_ent.cnt);
              sym_q   <= hi_ent.sym;
              state_q <= S_EXPAND;
            end else
              state_q <= S_RD_REQ;
          end
        end
        S_FLUSH: begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(4);
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decode.sv
// Directed bench for rle_decode: small SRAM model on port A, expected writes
// queued per test and checked by an independent write monitor.
module tb_rle_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] rle_addr = '0, rle_size = '0, message_addr = '0;
  logic [31:0] message_size;
  logic        done, port_A_clk, port_A_we;
  logic [15:0] port_A_addr;
  logic [31:0] port_A_data_in, port_A_data_out;

  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  bit  sb_en = 1'b1;
  int  checks = 0, failures = 0;

  logic        tb_we = 1'b0;
  logic [7:0]  tb_idx = '0;
  logic [31:0] tb_data = '0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  rle_decode #(.ADDR_W(16), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rle_addr(rle_addr), .rle_size(rle_size), .message_addr(message_addr),
    .message_size(message_size), .done(done),
    .port_A_clk(port_A_clk), .port_A_addr(port_A_addr),
    .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out),
    .port_A_we(port_A_we)
  );

  // SRAM model: one-cycle read latency; bench preload port used only while the DUT is idle.
  always @(posedge port_A_clk) begin
    if (tb_we) mem[tb_idx] <= tb_data;
    else if (port_A_we) mem[port_A_addr[9:2]] <= port_A_data_in;
    port_A_data_out <= mem[port_A_addr[9:2]];
  end

  // Write monitor: every DUT write must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && port_A_we && sb_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h", port_A_addr, port_A_data_in);
      end else begin
        mon_e = exp_q.pop_front();
        if (port_A_addr !== mon_e.addr || port_A_data_in !== mon_e.data) begin
          failures++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   port_A_addr, port_A_data_in, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_idx = a[9:2]; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Issue one decode; optionally fire a second start while busy, which must be ignored.
  task automatic run(input string tag, input logic [31:0] ra, input logic [31:0] rs,
                     input logic [31:0] ma, input logic [31:0] exp_size,
                     input bit busy, output int cyc);
    @(negedge clk);
    rle_addr = ra; rle_size = rs; message_addr = ma; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    if (busy) begin
      repeat (3) @(negedge clk);
      rle_addr = 32'h100; rle_size = 32'd2; message_addr = 32'h3F0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 4;
    end
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_message_size"}, message_size, exp_size);
    chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_message_size", message_size, 32'd0);
    chk("rst_we", {31'd0, port_A_we}, 32'd0);
    chk("rst_addr", {16'd0, port_A_addr}, 32'd0);
    chk("rst_data_in", port_A_data_in, 32'd0);
    reset = 1'b0;

    // single full word
    load(16'h100, 32'h0000_4104);
    expect_wr(16'h200, 32'h4141_4141);
    run("t1", 32'h100, 32'd2, 32'h200, 32'd4, 1'b0, cyc);

    // word then partial, with an ignored start mid-run
    load(16'h104, 32'h4202_4103);
    expect_wr(16'h210, 32'h4241_4141);
    expect_wr(16'h214, 32'h0000_0042);
    run("t2", 32'h104, 32'd4, 32'h210, 32'd5, 1'b1, cyc);

    // odd rle_size, flush only, message_addr upper bits truncated
    load(16'h108, 32'h0000_0703);
    expect_wr(16'h220, 32'h0007_0707);
    run("t3", 32'h108, 32'd3, 32'h0001_0220, 32'd3, 1'b0, cyc);

    // count-0 entry then a short run
    load(16'h10C, 32'h4302_0000);
    expect_wr(16'h230, 32'h0000_4343);
    run("t4", 32'h10C, 32'd4, 32'h230, 32'd2, 1'b0, cyc);

    // three entries over two words; unused upper half of second word ignored
    load(16'h120, 32'h1001_2002);
    load(16'h124, 32'hFFFF_3001);
    expect_wr(16'h260, 32'h3010_2020);
    run("t5", 32'h120, 32'd6, 32'h260, 32'd4, 1'b0, cyc);

    // empty stream: no writes, quick done
    run("t6", 32'h110, 32'd0, 32'h240, 32'd0, 1'b0, cyc);
    chk("t6_latency_ok", {31'd0, (cyc <= 3)}, 32'd1);

    // reset in the middle of a long run
    load(16'h114, 32'h0000_5050);
    sb_en = 1'b0;
    @(negedge clk);
    rle_addr = 32'h114; rle_size = 32'd2; message_addr = 32'h280; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_we", {31'd0, port_A_we}, 32'd0);
    chk("midrst_message_size", message_size, 32'd0);
    chk("midrst_addr", {16'd0, port_A_addr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb_en = 1'b1;

    // fresh stream after reset
    load(16'h118, 32'h6101_6205);
    expect_wr(16'h250, 32'h6262_6262);
    expect_wr(16'h254, 32'h0000_6162);
    run("t7", 32'h118, 32'd4, 32'h250, 32'd6, 1'b0, cyc);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
